// File: rtl/pong_io_pkg.sv
// Package pong_io_pkg
//  Shared constants and types for the pong input/control front-end.
//  - ADDR_WINDOW_BITS : width of the byte offset inside the CSR window (16 bytes)
//  - CSR_*            : word offsets (adr[3:2]) of the four CSRs
//  - CTRL_*           : bit positions inside the CTRL register
//  - wb_state_e       : Wishbone slave handshake states
//  - sel_to_mask()    : expands a 4-bit byte-lane select into a 32-bit bit mask
package pong_io_pkg;

  localparam int ADDR_WINDOW_BITS = 4;

  localparam logic [1:0] CSR_CTRL     = 2'd0;
  localparam logic [1:0] CSR_STATUS   = 2'd1;
  localparam logic [1:0] CSR_EVENT    = 2'd2;
  localparam logic [1:0] CSR_IRQ_MASK = 2'd3;

  localparam int CTRL_SOFT_RST = 0;
  localparam int CTRL_FREEZE   = 1;

  // WB_HOLD swallows the remainder of a strobe that stays high after its ack,
  // so a held strobe is acknowledged exactly once.
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ACK  = 2'd1,
    WB_HOLD = 2'd2
  } wb_state_e;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pong_input_ctrl_if.sv
// Interface pong_input_ctrl_if
//  Wishbone classic slave bus between the Caravel wrapper and the pong CSR block.
//  Signal names keep the slave-side view (_i driven by the master, _o by the slave).
//  - wbs_stb_i / wbs_cyc_i : strobe / cycle
//  - wbs_we_i              : write enable
//  - wbs_sel_i [3:0]       : byte-lane select
//  - wbs_dat_i [31:0]      : write data
//  - wbs_adr_i [31:0]      : byte address
//  - wbs_ack_o             : acknowledge
//  - wbs_dat_o [31:0]      : read data
//  Modports: slave (CSR block), master (wrapper / testbench).
interface pong_input_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/pong_input_debounce.sv
// Module pong_input_debounce
//  One button channel: 2-flop synchroniser, debounce counter, stable level and
//  a single-cycle rise pulse coincident with the stable level going high.
//  Ports:
//   clk_i     in  system clock
//   rst_ni    in  asynchronous active-low reset
//   raw_i     in  raw asynchronous pad
//   stable_o  out debounced level
//   rise_o    out 1 in the cycle the debounced level changes 0->1 (comb, pre-register)
//  A change on the synchronised level must persist 2**DB_BITS cycles before it
//  is accepted; any return to the current stable level restarts the count.
module pong_input_debounce #(
  parameter int DB_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  logic [1:0]         sync_q;
  logic               stable_q, stable_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;
  logic               s;

  assign s = sync_q[1];

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s != stable_q) begin
      // All-ones means this is the 2**DB_BITS-th differing cycle: accept it.
      if (cnt_q == {DB_BITS{1'b1}}) begin
        stable_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Rise is flagged in the same cycle the stable register takes the new level,
  // so the event CSR sets on the same edge.
  assign rise_o   = stable_d & ~stable_q;
  assign stable_o = stable_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_input_ctrl.sv
// Module pong_input_ctrl
//  Input/control front-end between the Caravel wrapper and the pong core.
//  Debounces N_IN button pads and exposes them through four Wishbone CSRs:
//   word 0 CTRL (SOFT_RST, FREEZE), 1 STATUS (levels), 2 EVENT (sticky rises, W1C),
//   3 IRQ_MASK.
//  Ports:
//   wb_clk_i    in   system clock (only clock domain)
//   wb_rst_ni   in   asynchronous active-low reset
//   wbs         slave modport of pong_input_ctrl_if (Wishbone CSR bus)
//   btn_raw_i   in   N_IN raw button pads
//   la_reset_i  in   logic-analyser game reset, active-high
//   btn_o       out  N_IN debounced levels, forced low while FREEZE is set
//   game_rst_o  out  registered reset to the pong core (la_reset_i | SOFT_RST)
//   irq_o       out  registered level interrupt, |(EVENT & IRQ_MASK)
module pong_input_ctrl
  import pong_io_pkg::*;
#(
  parameter int          N_IN      = 5,
  parameter int          DB_BITS   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  pong_input_ctrl_if.slave    wbs,
  input  logic [N_IN-1:0]     btn_raw_i,
  input  logic                la_reset_i,
  output logic [N_IN-1:0]     btn_o,
  output logic                game_rst_o,
  output logic                irq_o
);

  // ---------------------------------------------------------------- buttons
  logic [N_IN-1:0] btn_stable;
  logic [N_IN-1:0] btn_rise;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_btn
    pong_input_debounce #(
      .DB_BITS (DB_BITS)
    ) u_debounce (
      .clk_i    (wb_clk_i),
      .rst_ni   (wb_rst_ni),
      .raw_i    (btn_raw_i[gi]),
      .stable_o (btn_stable[gi]),
      .rise_o   (btn_rise[gi])
    );
  end

  // ---------------------------------------------------------------- bus FSM
  wb_state_e   state_q, state_d;
  logic        hit;
  logic        take;
  logic        ack_q;
  logic [31:0] dat_q;

  assign hit = wbs.wbs_stb_i & wbs.wbs_cyc_i &
               (wbs.wbs_adr_i[31:ADDR_WINDOW_BITS] == BASE_ADDR[31:ADDR_WINDOW_BITS]);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (hit) begin
          take    = 1'b1;
          state_d = WB_ACK;
        end
      end
      WB_ACK:  state_d = hit ? WB_HOLD : WB_IDLE;
      WB_HOLD: if (!hit) state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- CSRs
  logic [1:0]      ctrl_q, ctrl_d;
  logic [N_IN-1:0] event_q, event_d;
  logic [N_IN-1:0] mask_q, mask_d;
  logic            irq_q;
  logic            game_rst_q;
  logic [31:0]     wmask;
  logic [31:0]     wbits;
  logic [31:0]     rdata;
  logic [1:0]      word;
  logic            wr;

  assign word  = wbs.wbs_adr_i[3:2];
  assign wr    = take & wbs.wbs_we_i;
  assign wmask = sel_to_mask(wbs.wbs_sel_i);
  assign wbits = wbs.wbs_dat_i & wmask;

  always_comb begin
    ctrl_d  = ctrl_q;
    mask_d  = mask_q;
    event_d = event_q;
    if (wr && word == CSR_CTRL) begin
      ctrl_d = (ctrl_q & ~wmask[1:0]) | wbits[1:0];
    end
    if (wr && word == CSR_IRQ_MASK) begin
      mask_d = (mask_q & ~wmask[N_IN-1:0]) | wbits[N_IN-1:0];
    end
    if (wr && word == CSR_EVENT) begin
      event_d = event_q & ~wbits[N_IN-1:0];
    end
    // A new rise is OR-ed in last so it beats a simultaneous W1C clear.
    event_d = event_d | btn_rise;
  end

  // Read data is sampled from the pre-write register values.
  always_comb begin
    rdata = '0;
    case (word)
      CSR_CTRL:     rdata[1:0]      = ctrl_q;
      CSR_STATUS:   rdata[N_IN-1:0] = btn_stable;
      CSR_EVENT:    rdata[N_IN-1:0] = event_q;
      CSR_IRQ_MASK: rdata[N_IN-1:0] = mask_q;
      default:      rdata           = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= WB_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      ctrl_q     <= '0;
      event_q    <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      game_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ack_q      <= take;
      dat_q      <= take ? rdata : '0;
      ctrl_q     <= ctrl_d;
      event_q    <= event_d;
      mask_q     <= mask_d;
      irq_q      <= |(event_q & mask_q);
      game_rst_q <= la_reset_i | ctrl_q[CTRL_SOFT_RST];
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign btn_o         = btn_stable & ~{N_IN{ctrl_q[CTRL_FREEZE]}};
  assign irq_o         = irq_q;
  assign game_rst_o    = game_rst_q;

  // Address bits below the word offset carry no information for 32-bit CSRs.
  logic unused_bus;
  assign unused_bus = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

endmodule

// File: tb/tb_pong_input_ctrl.sv
// Testbench for pong_input_ctrl (N_IN=5, DB_BITS=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pong_input_ctrl;

  localparam int          N_IN   = 5;
  localparam int          DB     = 4;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_EVT  = BASE + 32'h8;
  localparam logic [31:0] A_MASK = BASE + 32'hC;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_IN-1:0] btn_raw = '0;
  logic            la_reset = 1'b0;
  logic [N_IN-1:0] btn;
  logic            game_rst;
  logic            irq;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  pong_input_ctrl_if wbs ();

  pong_input_ctrl #(
    .N_IN      (N_IN),
    .DB_BITS   (DB),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs        (wbs),
    .btn_raw_i  (btn_raw),
    .la_reset_i (la_reset),
    .btn_o      (btn),
    .game_rst_o (game_rst),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_dat_i = '0;
    wbs.wbs_adr_i = '0;
  endtask

  // One idle cycle, then a read; the expected value goes into the scoreboard
  // and is popped when the acknowledged data appears.
  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    tick(1);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_adr_i = adr;
    tick(1);
    check({tag, "_ack"}, 32'(wbs.wbs_ack_o), 32'd1);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, wbs.wbs_dat_o, e);
    $display("read  adr=0x%08h data=0x%08h", adr, wbs.wbs_dat_o);
    bus_idle();
  endtask

  // One idle cycle, then a write; returns in the ack cycle with the bus idle.
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input string tag);
    tick(1);
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = 1'b1;
    wbs.wbs_sel_i = sel;
    wbs.wbs_dat_i = dat;
    wbs.wbs_adr_i = adr;
    tick(1);
    check({tag, "_ack"}, 32'(wbs.wbs_ack_o), 32'd1);
    $display("write adr=0x%08h data=0x%08h sel=%b", adr, dat, sel);
    bus_idle();
  endtask

  initial begin
    int acks;
    int changes;
    bus_idle();

    // Reset values
    tick(2);
    check("rst_btn",      32'(btn),            32'h0);
    check("rst_game_rst", 32'(game_rst),       32'h1);
    check("rst_ack",      32'(wbs.wbs_ack_o),  32'h0);
    check("rst_dat",      wbs.wbs_dat_o,       32'h0);
    check("rst_irq",      32'(irq),            32'h0);
    rst_n = 1'b1;
    tick(1);
    check("game_rst_release", 32'(game_rst), 32'h0);

    // 1: reset mid-debounce discards the count
    btn_raw[0] = 1'b1;
    tick(8);
    rst_n = 1'b0;
    #1;
    check("midrst_btn",      32'(btn),           32'h0);
    check("midrst_game_rst", 32'(game_rst),      32'h1);
    check("midrst_ack",      32'(wbs.wbs_ack_o), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(17);
    check("postrst_btn_17", 32'(btn), 32'h00);
    tick(1);
    check("postrst_btn_18", 32'(btn), 32'h01);
    wb_read(A_EVT, 32'h01, "evt_after_rst_press");

    // 2: bouncing pad never reaches btn_o; final rise 18 cycles after last edge
    btn_raw[0] = 1'b0;
    tick(20);
    check("release_btn0", 32'(btn), 32'h00);
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      btn_raw[0] = ~btn_raw[0];
      for (int j = 0; j < 5; j++) begin
        tick(1);
        if (btn[0] !== 1'b0) changes++;
      end
    end
    check("bounce_steady", 32'(changes), 32'd0);
    btn_raw[0] = 1'b1;
    tick(17);
    check("bounce_btn_17", 32'(btn), 32'h00);
    tick(1);
    check("bounce_btn_18", 32'(btn), 32'h01);

    // 3: event, mask and interrupt
    wb_write(A_EVT, 32'h1F, 4'hF, "evt_clr_all");
    wb_read(A_EVT, 32'h00, "evt_cleared");
    wb_write(A_MASK, 32'h01, 4'hF, "mask_wr");
    wb_read(A_MASK, 32'h01, "mask_rd");
    btn_raw[0] = 1'b0;
    tick(20);
    btn_raw[0] = 1'b1;
    tick(18);
    check("press_btn0", 32'(btn), 32'h01);
    check("irq_same",   32'(irq), 32'h0);
    tick(1);
    check("irq_next",   32'(irq), 32'h1);
    wb_read(A_EVT, 32'h01, "evt_press");
    wb_write(A_EVT, 32'h01, 4'hF, "evt_w1c");
    check("irq_at_ack", 32'(irq), 32'h1);
    tick(1);
    check("irq_after_ack", 32'(irq), 32'h0);
    wb_read(A_EVT, 32'h00, "evt_w1c_done");

    // 4: W1C of EVENT[1] coinciding with a new btn1 rise
    btn_raw[1] = 1'b1;
    tick(16);
    wb_write(A_EVT, 32'h02, 4'hF, "evt_race");
    wb_read(A_EVT, 32'h02, "evt_race_set_wins");
    check("btn_both", 32'(btn), 32'h03);

    // 5: held strobe -> one ack; miss -> no ack; byte lanes
    tick(1);
    exp_q.push_back(32'h03);
    tag_q.push_back("status_held");
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_adr_i = A_STAT;
    acks = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k == 1) begin
        check("status_held_ack1", 32'(wbs.wbs_ack_o), 32'd1);
        check(tag_q.pop_front(), wbs.wbs_dat_o, exp_q.pop_front());
      end
      if (wbs.wbs_ack_o) acks++;
      if (k == 3) bus_idle();
    end
    check("status_single_ack", 32'(acks), 32'd1);
    $display("read  adr=0x%08h held 3 cycles acks=%0d", A_STAT, acks);

    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_adr_i = BASE + 32'h10;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (wbs.wbs_ack_o) acks++;
    end
    check("miss_no_ack", 32'(acks), 32'd0);
    check("miss_dat",    wbs.wbs_dat_o, 32'h0);
    $display("read  adr=0x%08h (outside window) acks=%0d", BASE + 32'h10, acks);
    bus_idle();

    wb_write(A_MASK, 32'hFFFF_FFFF, 4'b0001, "mask_sel0");
    wb_read(A_MASK, 32'h1F, "mask_sel0_rd");
    wb_write(A_MASK, 32'h0, 4'b1110, "mask_sel_hi");
    wb_read(A_MASK, 32'h1F, "mask_sel_hi_rd");
    check("irq_mask_all", 32'(irq), 32'h1);

    // 6: game reset sources and freeze
    wb_write(A_CTRL, 32'h1, 4'hF, "ctrl_soft_rst");
    check("game_rst_at_ack", 32'(game_rst), 32'h0);
    tick(1);
    check("game_rst_soft", 32'(game_rst), 32'h1);
    wb_read(A_CTRL, 32'h1, "ctrl_rd_soft");
    wb_write(A_CTRL, 32'h0, 4'hF, "ctrl_clear");
    tick(1);
    check("game_rst_clear", 32'(game_rst), 32'h0);
    la_reset = 1'b1;
    tick(1);
    check("game_rst_la", 32'(game_rst), 32'h1);
    la_reset = 1'b0;
    tick(1);
    check("game_rst_none", 32'(game_rst), 32'h0);
    wb_write(A_CTRL, 32'h2, 4'hF, "ctrl_freeze");
    check("freeze_btn", 32'(btn), 32'h00);
    wb_read(A_STAT, 32'h03, "freeze_status");
    wb_read(A_CTRL, 32'h02, "ctrl_rd_freeze");
    check("freeze_game_rst", 32'(game_rst), 32'h0);
    wb_write(A_CTRL, 32'h0, 4'hF, "ctrl_unfreeze");
    check("unfreeze_btn", 32'(btn), 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
